// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter/rotator.
// The payload is sized for the widest supported operand; narrower builds use the low bits.
package barrel_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_AMT_W = 6;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef struct packed {
    logic [MAX_W-1:0]     data;
    logic [MAX_AMT_W-1:0] amt;
    op_e                  op;
    logic                 sign;
    logic                 carry;
  } stage_t;

endpackage

// File: rtl/barrel_stage.sv
// One log2 stage: conditionally shift/rotate by SHIFT, then register with a valid bit.
// Handshake: a beat moves on in_valid && in_ready; in_ready = !held || out_ready.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  stage_t in_p,
  output logic   out_valid,
  input  logic   out_ready,
  output stage_t out_p
);

  localparam int K = $clog2(SHIFT);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] fill;
  stage_t           nxt;
  logic             v;
  stage_t           p;

  always_comb begin
    d    = in_p.data[WIDTH-1:0];
    fill = '0;
    case (in_p.op)
      OP_ROR, OP_ROL: fill = d << (WIDTH - SHIFT);
      OP_SRA:         fill = in_p.sign ? ~({WIDTH{1'b1}} >> SHIFT) : '0;
      default:        fill = '0;
    endcase
    nxt = in_p;
    if (in_p.amt[K]) nxt.data[WIDTH-1:0] = (d >> SHIFT) | fill;
  end

  assign in_ready = !v || out_ready;

  // Contents only change when a slot opens, so a stalled result holds still.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= 1'b0;
      p <= '0;
    end else if (in_ready) begin
      v <= in_valid;
      if (in_valid) p <= nxt;
    end
  end

  assign out_valid = v;
  assign out_p     = p;

endmodule

// File: rtl/barrel_rotate_pipe.sv
// Pipelined ROR/ROL/SRL/SRA, one register per log2 stage, valid/ready on both sides.
// Optional out_carry (last bit shifted out) when BARREL_CARRY_EN is defined.
module barrel_rotate_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARREL_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  op_e              op_in;
  logic [AMT_W-1:0] amt_neg;
  logic [AMT_W-1:0] amt_eff;
  stage_t           p0;

  // ROL becomes a right rotate by -amt mod WIDTH before entering the chain.
  always_comb begin
    op_in   = op_e'(in_op);
    amt_neg = AMT_W'(0) - in_amt;
    amt_eff = (op_in == OP_ROL) ? amt_neg : in_amt;
    p0      = '0;
    p0.data[WIDTH-1:0] = in_data;
    p0.amt  = MAX_AMT_W'(amt_eff);
    p0.op   = op_in;
    p0.sign = in_data[WIDTH-1];
`ifdef BARREL_CARRY_EN
    if (in_amt != '0)
      p0.carry = (op_in == OP_ROL) ? in_data[amt_neg] : in_data[in_amt - AMT_W'(1)];
`endif
  end

  stage_t sp [AMT_W+1];
  logic   sv [AMT_W+1];
  logic   sr [AMT_W+1];

  assign sp[0]     = p0;
  assign sv[0]     = in_valid;
  assign sr[AMT_W] = out_ready;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    barrel_stage #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (sv[k]),
      .in_ready (sr[k]),
      .in_p     (sp[k]),
      .out_valid(sv[k+1]),
      .out_ready(sr[k+1]),
      .out_p    (sp[k+1])
    );
  end

  assign in_ready  = sr[0];
  assign out_valid = sv[AMT_W];
  assign out_data  = sp[AMT_W].data[WIDTH-1:0];
`ifdef BARREL_CARRY_EN
  assign out_carry = sp[AMT_W].carry;
`endif

  logic unused_tail;
  assign unused_tail = ^sp[AMT_W];

endmodule
